lenet_layer_sequencer: RTL and testbench

Top-level layer scheduler for the LeNet-5 accelerator. It runs the layer blocks (conv, pool, middle conv/pool, FC, ...) strictly in order by driving one held enable per layer and waiting for that layer's level `done`. It enforces the layer enable/done protocol: the enable is held until `done` rises, then dropped until `done` falls. It also provides a per-layer watchdog, a cycle count of the last completed layer, and abort/error reporting to the host-side wrapper.

---
 rtl/lenet_pkg.sv | 33 +++
 rtl/layer_watchdog.sv | 33 +++
 rtl/lenet_layer_sequencer.sv | 159 +++++++++++++++
 tb/tb_lenet_layer_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet-5 accelerator: sequencer state encoding,
// layer indices and the one-hot state convention of the per-layer FSMs.
package lenet_pkg;

    localparam int NUM_LAYERS = 5;

    localparam int LAYER_C1 = 0;
    localparam int LAYER_S2 = 1;
    localparam int LAYER_C3 = 2;
    localparam int LAYER_S4 = 3;
    localparam int LAYER_FC = 4;

    localparam logic [4:0] SEQ_IDLE    = 5'b00001;
    localparam logic [4:0] SEQ_RUN     = 5'b00010;
    localparam logic [4:0] SEQ_RELEASE = 5'b00100;
    localparam logic [4:0] SEQ_FINISH  = 5'b01000;
    localparam logic [4:0] SEQ_ERROR   = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE    = SEQ_IDLE,
        ST_RUN     = SEQ_RUN,
        ST_RELEASE = SEQ_RELEASE,
        ST_FINISH  = SEQ_FINISH,
        ST_ERROR   = SEQ_ERROR
    } seq_state_t;

    // Layer FSMs: done is a level that stays high while the layer sits in LST_DONE.
    localparam logic [3:0] LST_IDLE  = 4'b0001;
    localparam logic [3:0] LST_RUN   = 4'b0010;
    localparam logic [3:0] LST_DONE  = 4'b0100;
    localparam logic [3:0] LST_CLEAR = 4'b1000;

endpackage

// File: rtl/layer_watchdog.sv
// Saturating per-layer cycle counter with a timeout compare; a zero
// TIMEOUT_CYCLES disables the expiry output.
module layer_watchdog #(
    parameter int          CNT_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               WD_ON = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !(&count_reg)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count   = count_reg;
    assign expired = WD_ON && (count_reg == LIMIT);

endmodule

// File: rtl/lenet_layer_sequencer.sv
// Runs the LeNet layer blocks strictly in order using a held enable / level
// done handshake, with per-layer watchdog, cycle reporting and abort.
module lenet_layer_sequencer #(
    parameter int          NUM_LAYERS     = 5,
    parameter int          CNT_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF,
    parameter int          LW             = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  clear_err,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [LW-1:0]         cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LW-1:0]         err_layer,
    output logic [CNT_W-1:0]      last_cycles
);
    import lenet_pkg::*;

    seq_state_t              state_reg, state_next;
    logic [NUM_LAYERS-1:0]   layer_en_reg, layer_en_next;
    logic [LW-1:0]           cur_layer_reg, cur_layer_next;
    logic                    err_reg, err_next;
    logic [LW-1:0]           err_layer_reg, err_layer_next;
    logic [CNT_W-1:0]        last_cycles_reg, last_cycles_next;

    logic                    wd_clear, wd_enable, wd_expired;
    logic [CNT_W-1:0]        wd_count, count_with_done;
    logic [NUM_LAYERS-1:0]   done_hits;
    logic                    active_done, is_last;
    logic [LW-1:0]           cur_layer_inc;

    layer_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .count   (wd_count),
        .expired (wd_expired)
    );

    // Only the active layer's done matters; stray done levels are masked here.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_done_sel
        assign done_hits[gi] = layer_done[gi] && (cur_layer_reg == LW'(gi));
    end

    assign active_done     = |done_hits;
    assign is_last         = (cur_layer_reg == LW'(NUM_LAYERS - 1));
    assign cur_layer_inc   = cur_layer_reg + LW'(1);
    assign count_with_done = (&wd_count) ? wd_count : wd_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            layer_en_reg    <= '0;
            cur_layer_reg   <= '0;
            err_reg         <= 1'b0;
            err_layer_reg   <= '0;
            last_cycles_reg <= '0;
        end else begin
            state_reg       <= state_next;
            layer_en_reg    <= layer_en_next;
            cur_layer_reg   <= cur_layer_next;
            err_reg         <= err_next;
            err_layer_reg   <= err_layer_next;
            last_cycles_reg <= last_cycles_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        layer_en_next    = layer_en_reg;
        cur_layer_next   = cur_layer_reg;
        err_next         = err_reg;
        err_layer_next   = err_layer_reg;
        last_cycles_next = last_cycles_reg;
        wd_clear         = 1'b0;
        wd_enable        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                layer_en_next = '0;
                if (start) begin
                    state_next     = ST_RUN;
                    cur_layer_next = '0;
                    layer_en_next  = NUM_LAYERS'(1);
                    wd_clear       = 1'b1;
                end
            end
            ST_RUN: begin
                wd_enable = 1'b1;
                // Abort beats done, and done beats the watchdog in the same cycle.
                if (abort) begin
                    state_next    = ST_IDLE;
                    layer_en_next = '0;
                end else if (active_done) begin
                    state_next       = ST_RELEASE;
                    layer_en_next    = '0;
                    last_cycles_next = count_with_done;
                end else if (wd_expired) begin
                    state_next     = ST_ERROR;
                    layer_en_next  = '0;
                    err_next       = 1'b1;
                    err_layer_next = cur_layer_reg;
                end
            end
            ST_RELEASE: begin
                layer_en_next = '0;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!active_done) begin
                    if (is_last) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next     = ST_RUN;
                        cur_layer_next = cur_layer_inc;
                        layer_en_next  = NUM_LAYERS'(1) << cur_layer_inc;
                        wd_clear       = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                layer_en_next = '0;
                state_next    = ST_IDLE;
            end
            ST_ERROR: begin
                layer_en_next = '0;
                if (clear_err) begin
                    state_next     = ST_IDLE;
                    err_next       = 1'b0;
                    err_layer_next = '0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                layer_en_next = '0;
            end
        endcase
    end

    assign layer_en    = layer_en_reg;
    assign cur_layer   = cur_layer_reg;
    assign err         = err_reg;
    assign err_layer   = err_layer_reg;
    assign last_cycles = last_cycles_reg;
    assign busy        = (state_reg == ST_RUN) || (state_reg == ST_RELEASE) ||
                         (state_reg == ST_FINISH);
    // An abort arriving in FINISH suppresses the completion pulse.
    assign done        = (state_reg == ST_FINISH) && !abort;

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Scoreboard bench for lenet_layer_sequencer: behavioural layer models answer
// the enables, expected enable/done/error events are queued and matched in order.
module tb_lenet_layer_sequencer;

    localparam int NL         = 5;
    localparam int CW         = 20;
    localparam int TO         = 50;
    localparam int LWD        = 3;
    localparam int DONE_DELAY = 10;
    localparam int EV_EN      = 0;
    localparam int EV_DONE    = 1;
    localparam int EV_ERR     = 2;

    typedef struct {
        int kind;
        int value;
        int aux;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          clear_err = 1'b0;
    logic [NL-1:0] layer_done;
    logic [NL-1:0] model_done = '0;
    logic [NL-1:0] spur_done = '0;
    logic [NL-1:0] never_done = '0;
    int            sticky [NL] = '{default: 0};
    int            run_cnt [NL] = '{default: 0};
    int            hold_cnt [NL] = '{default: 0};

    logic [NL-1:0]  layer_en;
    logic [LWD-1:0] cur_layer, err_layer;
    logic           busy, done, err;
    logic [CW-1:0]  last_cycles;

    ev_t           sb [$];
    int            checks = 0;
    int            errors = 0;
    logic [NL-1:0] prev_en = '0;
    logic          prev_err = 1'b0;
    int            zero_cnt = 0;
    int            en_high = 0;

    lenet_layer_sequencer #(
        .NUM_LAYERS     (NL),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TO),
        .LW             (LWD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .clear_err   (clear_err),
        .layer_done  (layer_done),
        .layer_en    (layer_en),
        .cur_layer   (cur_layer),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_layer   (err_layer),
        .last_cycles (last_cycles)
    );

    always #5 clk = ~clk;

    assign layer_done = model_done | spur_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int value, input int aux);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.aux   = aux;
        sb.push_back(e);
    endtask

    // Full inference: every layer needs DONE_DELAY+1 RUN cycles including the done cycle.
    task automatic push_run(input int sticky_layer, input int extra);
        for (int k = 0; k < NL; k++) begin
            int gap;
            gap = (k == 0) ? -1 : ((k - 1 == sticky_layer) ? 1 + extra : 1);
            push_ev(EV_EN, 1 << k, gap);
        end
        push_ev(EV_DONE, DONE_DELAY + 1, NL - 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic wait_en(input string tag, input logic [NL-1:0] value, input int max_cycles);
        for (int i = 0; i < max_cycles && layer_en != value; i++) tick();
        check(tag, layer_en, value);
    endtask

    task automatic take(input int kind, input string tag, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1;
        e.value = 0;
        e.aux = 0;
        check({tag, "_queued"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_kind"}, kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    // Layer model: done rises after DONE_DELAY+1 enabled cycles, falls 1+sticky cycles after en drops.
    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (layer_en[k]) begin
                hold_cnt[k] = 0;
                run_cnt[k]  = run_cnt[k] + 1;
                if (!never_done[k] && run_cnt[k] > DONE_DELAY) model_done[k] = 1'b1;
            end else if (model_done[k]) begin
                hold_cnt[k] = hold_cnt[k] + 1;
                if (hold_cnt[k] > sticky[k]) begin
                    model_done[k] = 1'b0;
                    run_cnt[k]    = 0;
                    hold_cnt[k]   = 0;
                end
            end else begin
                run_cnt[k]  = 0;
                hold_cnt[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (layer_en != prev_en && layer_en != '0) begin
            $display("t=%0t enable %b after %0d idle cycles", $time, layer_en, zero_cnt);
            take(EV_EN, "en", e, ok);
            if (ok) begin
                check("en_value", layer_en, e.value);
                if (e.aux >= 0) check("en_gap", zero_cnt, e.aux);
            end
            check("en_onehot", $onehot(layer_en), 1);
            en_high = 1;
        end else if (layer_en != '0) begin
            en_high = en_high + 1;
        end
        zero_cnt = (layer_en == '0) ? zero_cnt + 1 : 0;
        if (done) begin
            $display("t=%0t done layer %0d last_cycles %0d", $time, cur_layer, last_cycles);
            take(EV_DONE, "done", e, ok);
            if (ok) begin
                check("done_last_cycles", last_cycles, e.value);
                check("done_cur_layer", cur_layer, e.aux);
            end
            check("done_busy", busy, 1);
        end
        if (err && !prev_err) begin
            $display("t=%0t error layer %0d after %0d run cycles", $time, err_layer, en_high);
            take(EV_ERR, "err", e, ok);
            if (ok) begin
                check("err_layer", err_layer, e.value);
                check("err_run_cycles", en_high, e.aux);
            end
            check("err_en_off", layer_en, 0);
        end
        prev_en  = layer_en;
        prev_err = err;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_en", layer_en, 0);
        check("rst_cur", cur_layer, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_layer", err_layer, 0);
        check("rst_last", last_cycles, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Nominal run
        push_run(-1, 0);
        pulse_start();
        drain("nominal", 400);
        tick();
        check("nom_busy_after", busy, 0);
        check("nom_done_after", done, 0);
        check("nom_last_hold", last_cycles, DONE_DELAY + 1);

        // Sticky done on layer 2
        sticky[2] = 4;
        push_run(2, 4);
        pulse_start();
        drain("sticky", 400);
        sticky[2] = 0;
        tick();

        // Spurious done on layer 4 and start while busy
        push_run(-1, 0);
        pulse_start();
        repeat (3) tick();
        spur_done = 5'b10000;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("spur_en", layer_en, 1);
        check("spur_cur", cur_layer, 0);
        tick();
        spur_done = '0;
        drain("spurious", 400);
        tick();

        // Watchdog timeout on layer 1
        never_done[1] = 1'b1;
        push_ev(EV_EN, 1, -1);
        push_ev(EV_EN, 2, 1);
        push_ev(EV_ERR, 1, TO);
        pulse_start();
        drain("timeout", 400);
        pulse_start();
        repeat (3) tick();
        check("err_hold", err, 1);
        check("err_hold_layer", err_layer, 1);
        check("err_start_ignored", busy, 0);
        check("err_en_zero", layer_en, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_err", err, 0);
        check("clear_err_layer", err_layer, 0);
        never_done[1] = 1'b0;
        tick();

        // Abort in layer 3 in the same cycle its done is sampled
        push_ev(EV_EN, 1, -1);
        push_ev(EV_EN, 2, 1);
        push_ev(EV_EN, 4, 1);
        push_ev(EV_EN, 8, 1);
        pulse_start();
        for (int i = 0; i < 300 && !(layer_en[3] && layer_done[3]); i++) tick();
        check("abort_reach", layer_en[3] & layer_done[3], 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_en", layer_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cur", cur_layer, 3);
        repeat (3) tick();
        check("abort_sb_empty", sb.size(), 0);
        push_run(-1, 0);
        pulse_start();
        drain("after_abort", 400);
        tick();

        // Asynchronous reset between edges while layer 2 runs
        push_ev(EV_EN, 1, -1);
        push_ev(EV_EN, 2, 1);
        push_ev(EV_EN, 4, 1);
        pulse_start();
        wait_en("reach_layer2", 5'b00100, 300);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("async_en", layer_en, 0);
        check("async_cur", cur_layer, 0);
        check("async_busy", busy, 0);
        check("async_last", last_cycles, 0);
        check("async_err", err, 0);
        check("async_sb_empty", sb.size(), 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_en", layer_en, 0);
        push_run(-1, 0);
        pulse_start();
        drain("after_reset", 400);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
